sc_datamem_io_param: RTL

SC_DATAMEM_IO_PARAM -- requirements
Module: sc_datamem_io_param

---
 rtl/sc_datamem_io_param.sv | 98 +++++++++
 1 files changed

// File: rtl/sc_datamem_io_param.sv
// sc_datamem_io_param: word RAM with memory-mapped output/input ports; the
// optional macro DMEM_IN_CHANGE_EN adds sticky input-change flags and the status word.
module sc_datamem_io_param #(
    parameter int DEPTH   = 32,
    parameter int IO_BIT  = 7,
    parameter int NUM_OUT = 2,
    parameter int NUM_IN  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic                  re,
    output logic [31:0]           dataout,
    output logic                  rvalid,
    output logic [32*NUM_OUT-1:0] out_ports,
    input  logic [32*NUM_IN-1:0]  in_ports,
    output logic [NUM_IN-1:0]     in_changed
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]              mem [DEPTH];
    logic [NUM_OUT-1:0][31:0] out_regs;
    logic [NUM_IN-1:0][31:0]  sync1, sync2;
    logic                     io;
    logic [4:0]               w;
    logic [AW-1:0]            idx;
    logic [31:0]              wmask, status, rd_io;

    assign io        = addr[IO_BIT];
    assign w         = addr[6:2];
    assign idx       = addr[AW+1:2];
    assign wmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign out_ports = out_regs;

    always_comb begin
        rd_io = '0;
        for (int k = 0; k < NUM_OUT; k++)
            rd_io = (w == 5'(k)) ? out_regs[k] : rd_io;
        for (int j = 0; j < NUM_IN; j++)
            rd_io = (w == 5'(16 + j)) ? sync2[j] : rd_io;
        rd_io = (w == 5'd31) ? status : rd_io;
    end

    // RAM is never reset, but a write coinciding with reset is still dropped
    always_ff @(posedge clock)
        if (!reset && we && !io)
            mem[idx] <= (mem[idx] & ~wmask) | (datain & wmask);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_regs <= '0;
            sync1    <= '0;
            sync2    <= '0;
            dataout  <= '0;
            rvalid   <= 1'b0;
        end else begin
            sync1  <= in_ports;
            sync2  <= sync1;
            rvalid <= re;
            if (re)
                dataout <= io ? rd_io : mem[idx];
            for (int k = 0; k < NUM_OUT; k++)
                if (we && io && w == 5'(k))
                    out_regs[k] <= (out_regs[k] & ~wmask) | (datain & wmask);
        end
    end

`ifdef DMEM_IN_CHANGE_EN
    logic [NUM_IN-1:0][31:0] prev;
    logic [NUM_IN-1:0]       flags, set;

    always_comb begin
        set = '0;
        for (int j = 0; j < NUM_IN; j++)
            set[j] = sync2[j] != prev[j];
    end

    // a status read clears the flags, but a change on the same edge still sets
    always_ff @(posedge clock) begin
        if (reset) begin
            prev  <= '0;
            flags <= '0;
        end else begin
            prev  <= sync2;
            flags <= ((re && io && w == 5'd31) ? '0 : flags) | set;
        end
    end

    assign in_changed = flags;
    assign status     = 32'(flags);
`else
    assign in_changed = '0;
    assign status     = '0;
`endif
endmodule
